// File: rtl/uart_pkg.sv
// Shared constants and types for the UART boot loader: status bit positions,
// byte lane, error codes and the loader state encoding.
package uart_pkg;

  localparam int RX_READY      = 31;
  localparam int FRAMING_ERROR = 30;
  localparam int TX_READY      = 29;

  localparam int BYTE_HI = 31;
  localparam int BYTE_LO = 24;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_FRAMING  = 2'b01;
  localparam logic [1:0] ERR_OVERSIZE = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_POLL_RX   = 4'd1,
    S_READ_DATA = 4'd2,
    S_POLL_TX   = 4'd3,
    S_WRITE_TX  = 4'd4,
    S_TX_GUARD  = 4'd5,
    S_CHECK     = 4'd6,
    S_STORE     = 4'd7,
    S_DONE      = 4'd8,
    S_ERROR     = 4'd9
  } state_t;

endpackage

// File: rtl/uart_bus_port.sv
// One-cycle access port onto the UART register bus. The request lines come
// straight from loader registers; ack and decoded read data are same-cycle.
module uart_bus_port
  import uart_pkg::*;
(
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic        i_sel_data,
  input  logic [7:0]  i_tx_byte,
  output logic        o_uart_read,
  output logic        o_uart_write,
  output logic        o_uart_data_cs,
  output logic        o_uart_status_cs,
  output logic [31:0] o_uart_data_out,
  input  logic [31:0] i_uart_data_in,
  input  logic        i_uart_data_in_valid,
  output logic        o_ack,
  output logic [7:0]  o_rx_byte,
  output logic        o_rx_ready,
  output logic        o_framing,
  output logic        o_tx_ready
);

  logic w_active;
  logic w_unused_low;

  assign w_active         = i_rd | i_wr;
  assign o_uart_read      = i_rd;
  assign o_uart_write     = i_wr & ~i_rd;
  assign o_uart_data_cs   = w_active & i_sel_data;
  assign o_uart_status_cs = w_active & ~i_sel_data;
  assign o_uart_data_out  = {i_tx_byte, 24'h000000};

  // A read without valid is not acknowledged, so the caller simply repeats it.
  assign o_ack      = (i_wr & ~i_rd) | (i_rd & i_uart_data_in_valid);
  assign o_rx_byte  = i_uart_data_in[BYTE_HI:BYTE_LO];
  assign o_rx_ready = i_uart_data_in[RX_READY];
  assign o_framing  = i_uart_data_in[FRAMING_ERROR];
  assign o_tx_ready = i_uart_data_in[TX_READY];

  assign w_unused_low = ^i_uart_data_in[23:0];

endmodule

// File: rtl/uart_boot_loader.sv
// Boot-time bus master: reads a big-endian word-count header and payload
// from the UART, echoes every byte, and writes each word to memory.
module uart_boot_loader
  import uart_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR       = 30'h0000000,
  parameter int unsigned MAX_WORDS       = 4096,
  parameter int unsigned TX_GUARD_CYCLES = 2
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic        uart_read,
  output logic        uart_write,
  output logic        uart_data_cs,
  output logic        uart_status_cs,
  output logic [31:0] uart_data_out,
  input  logic [31:0] uart_data_in,
  input  logic        uart_data_in_valid,
  output logic        mem_write,
  output logic [29:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic        mem_ack
);

  localparam logic [31:0] MAX_W      = 32'(MAX_WORDS);
  localparam logic [7:0]  GUARD_LAST = 8'(TX_GUARD_CYCLES - 1);

  state_t      r_state;
  logic        r_acc_rd;
  logic        r_acc_wr;
  logic        r_acc_data;
  logic [7:0]  r_tx_byte;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_error;
  logic        r_mem_write;
  logic [29:0] r_mem_address;
  logic [31:0] r_mem_data;
  logic [31:0] r_word;
  logic [1:0]  r_byte_cnt;
  logic        r_hdr_done;
  logic [31:0] r_remaining;
  logic [29:0] r_index;
  logic        r_fe;
  logic [7:0]  r_guard;

  logic        w_ack;
  logic [7:0]  w_rx_byte;
  logic        w_rx_ready;
  logic        w_framing;
  logic        w_tx_ready;

  uart_bus_port u_port (
    .i_rd                 (r_acc_rd),
    .i_wr                 (r_acc_wr),
    .i_sel_data           (r_acc_data),
    .i_tx_byte            (r_tx_byte),
    .o_uart_read          (uart_read),
    .o_uart_write         (uart_write),
    .o_uart_data_cs       (uart_data_cs),
    .o_uart_status_cs     (uart_status_cs),
    .o_uart_data_out      (uart_data_out),
    .i_uart_data_in       (uart_data_in),
    .i_uart_data_in_valid (uart_data_in_valid),
    .o_ack                (w_ack),
    .o_rx_byte            (w_rx_byte),
    .o_rx_ready           (w_rx_ready),
    .o_framing            (w_framing),
    .o_tx_ready           (w_tx_ready)
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign mem_write    = r_mem_write;
  assign mem_address  = r_mem_address;
  assign mem_data_out = r_mem_data;

  // Loader FSM; bus request lines are set on entry to the state that uses them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_acc_rd      <= 1'b0;
      r_acc_wr      <= 1'b0;
      r_acc_data    <= 1'b0;
      r_tx_byte     <= 8'h00;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= ERR_NONE;
      r_mem_write   <= 1'b0;
      r_mem_address <= BASE_ADDR;
      r_mem_data    <= 32'h00000000;
      r_word        <= 32'h00000000;
      r_byte_cnt    <= 2'd0;
      r_hdr_done    <= 1'b0;
      r_remaining   <= 32'd0;
      r_index       <= 30'd0;
      r_fe          <= 1'b0;
      r_guard       <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_POLL_RX;
            r_busy     <= 1'b1;
            r_error    <= ERR_NONE;
            r_byte_cnt <= 2'd0;
            r_index    <= 30'd0;
            r_hdr_done <= 1'b0;
            r_acc_rd   <= 1'b1;
            r_acc_data <= 1'b0;
          end
        end
        S_POLL_RX: begin
          if (w_ack && w_rx_ready) begin
            r_state    <= S_READ_DATA;
            r_fe       <= w_framing;
            r_acc_data <= 1'b1;
          end
        end
        S_READ_DATA: begin
          if (w_ack) begin
            if (r_fe) begin
              r_state  <= S_ERROR;
              r_busy   <= 1'b0;
              r_error  <= ERR_FRAMING;
              r_acc_rd <= 1'b0;
            end else begin
              r_word     <= {r_word[23:0], w_rx_byte};
              r_state    <= S_POLL_TX;
              r_acc_data <= 1'b0;
            end
          end
        end
        S_POLL_TX: begin
          if (w_ack && w_tx_ready) begin
            r_state    <= S_WRITE_TX;
            r_acc_rd   <= 1'b0;
            r_acc_wr   <= 1'b1;
            r_acc_data <= 1'b1;
            r_tx_byte  <= r_word[7:0];
          end
        end
        S_WRITE_TX: begin
          r_state    <= S_TX_GUARD;
          r_acc_wr   <= 1'b0;
          r_acc_data <= 1'b0;
          r_guard    <= 8'd0;
        end
        S_TX_GUARD: begin
          if (r_guard == GUARD_LAST) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (r_hdr_done) begin
                r_state       <= S_STORE;
                r_mem_write   <= 1'b1;
                r_mem_address <= BASE_ADDR + r_index;
                r_mem_data    <= r_word;
              end else begin
                r_state <= S_CHECK;
              end
            end else begin
              r_state  <= S_POLL_RX;
              r_acc_rd <= 1'b1;
            end
          end else begin
            r_guard <= r_guard + 8'd1;
          end
        end
        S_CHECK: begin
          if (r_word == 32'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_word > MAX_W) begin
            r_state <= S_ERROR;
            r_busy  <= 1'b0;
            r_error <= ERR_OVERSIZE;
          end else begin
            r_remaining <= r_word;
            r_hdr_done  <= 1'b1;
            r_state     <= S_POLL_RX;
            r_acc_rd    <= 1'b1;
          end
        end
        S_STORE: begin
          if (mem_ack) begin
            r_mem_write <= 1'b0;
            r_index     <= r_index + 30'd1;
            r_remaining <= r_remaining - 32'd1;
            if (r_remaining == 32'd1) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state  <= S_POLL_RX;
              r_acc_rd <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERROR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: a small UART/memory responder model
// plus one task per scenario with hand-computed expectations.
module tb_uart_boot_loader;

  localparam logic [29:0] BASE = 30'h0000100;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  error;
  logic        uart_read;
  logic        uart_write;
  logic        uart_data_cs;
  logic        uart_status_cs;
  logic [31:0] uart_data_out;
  logic [31:0] uart_data_in;
  logic        uart_data_in_valid;
  logic        mem_write;
  logic [29:0] mem_address;
  logic [31:0] mem_data_out;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_bytes [0:15];
  int   rx_len    = 0;
  int   fe_at     = -1;
  int   ack_delay = 0;
  int   tx_hold   = 0;
  logic valid_gap = 1'b0;
  logic model_clr = 1'b0;

  int rx_ptr, tx_block, echo_cnt, mem_cnt, mem_wait, mem_run, mem_run_max;
  int stab_viol, store_strobe, strobe_viol, low_viol, pend_viol, blocked_polls, done_cnt, cyc;
  logic        pend_echo, prev_pending;
  logic [29:0] prev_addr;
  logic [31:0] prev_data;
  logic [7:0]  echo_log [0:15];
  logic [29:0] maddr_log [0:3];
  logic [31:0] mdata_log [0:3];
  logic        w_valid, w_rx_rdy, w_tx_rdy;

  uart_boot_loader #(
    .BASE_ADDR(BASE), .MAX_WORDS(4096), .TX_GUARD_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .uart_read(uart_read), .uart_write(uart_write), .uart_data_cs(uart_data_cs),
    .uart_status_cs(uart_status_cs), .uart_data_out(uart_data_out),
    .uart_data_in(uart_data_in), .uart_data_in_valid(uart_data_in_valid),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  // UART and memory responders; invalid reads return all-ones to expose misuse.
  always_comb begin
    w_valid  = uart_read && !(valid_gap && (cyc % 3 == 0));
    w_rx_rdy = (rx_ptr < rx_len);
    w_tx_rdy = (tx_block == 0);
    uart_data_in = 32'hFFFFFFFF;
    if (w_valid) begin
      if (uart_status_cs) uart_data_in = {w_rx_rdy, (rx_ptr == fe_at), w_tx_rdy, 29'h0};
      else                uart_data_in = {rx_bytes[rx_ptr[3:0]], 24'h000000};
    end
    uart_data_in_valid = w_valid;
    mem_ack = mem_write && (mem_wait == ack_delay);
  end

  // Bus monitor: UART byte stream, echo log, memory log and protocol counters.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (model_clr) begin
      rx_ptr <= 0; tx_block <= 0; echo_cnt <= 0; mem_cnt <= 0; mem_wait <= 0;
      mem_run <= 0; mem_run_max <= 0; stab_viol <= 0; store_strobe <= 0;
      strobe_viol <= 0; low_viol <= 0; pend_viol <= 0; blocked_polls <= 0;
      done_cnt <= 0; pend_echo <= 1'b0; prev_pending <= 1'b0;
    end else begin
      if (uart_read && uart_data_cs && uart_data_in_valid) begin
        rx_ptr <= rx_ptr + 1;
        if (pend_echo) pend_viol <= pend_viol + 1;
        pend_echo <= 1'b1;
      end
      if (uart_write && uart_data_cs) begin
        echo_log[echo_cnt[3:0]] <= uart_data_out[31:24];
        echo_cnt  <= echo_cnt + 1;
        tx_block  <= tx_hold;
        pend_echo <= 1'b0;
        if (uart_data_out[23:0] != 24'h0) low_viol <= low_viol + 1;
      end else if (tx_block > 0) begin
        tx_block <= tx_block - 1;
      end
      if (uart_read && uart_status_cs && uart_data_in_valid && tx_block != 0)
        blocked_polls <= blocked_polls + 1;
      if ((uart_read && uart_write) || (uart_data_cs && uart_status_cs) ||
          ((uart_read || uart_write) && !(uart_data_cs || uart_status_cs)))
        strobe_viol <= strobe_viol + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (mem_write) begin
        mem_run <= mem_run + 1;
        if (mem_run + 1 > mem_run_max) mem_run_max <= mem_run + 1;
        if (prev_pending && (mem_address != prev_addr || mem_data_out != prev_data))
          stab_viol <= stab_viol + 1;
        if (uart_read || uart_write) store_strobe <= store_strobe + 1;
        prev_addr    <= mem_address;
        prev_data    <= mem_data_out;
        prev_pending <= !mem_ack;
        if (mem_ack) begin
          maddr_log[mem_cnt[1:0]] <= mem_address;
          mdata_log[mem_cnt[1:0]] <= mem_data_out;
          mem_cnt  <= mem_cnt + 1;
          mem_wait <= 0;
          mem_run  <= 0;
        end else begin
          mem_wait <= mem_wait + 1;
        end
      end else begin
        mem_run <= 0; mem_wait <= 0; prev_pending <= 1'b0;
      end
    end
  end

  task automatic load_stream(input logic [127:0] stream, input int n, input int fe);
    for (int i = 0; i < 16; i++) rx_bytes[i] = stream[127-8*i -: 8];
    rx_len = n;
    fe_at  = fe;
    @(negedge clock); model_clr = 1'b1;
    @(negedge clock); model_clr = 1'b0;
  endtask

  task automatic run_load(input int limit, input int stray_at, output logic saw_done);
    int waited;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin $display("FAIL busy_after_start got=%b exp=1", busy); errors++; end
    waited = 0;
    while (busy && waited < limit) begin
      start = (waited == stray_at);
      @(negedge clock);
      waited++;
    end
    start = 1'b0;
    saw_done = done;
    checks++;
    if (busy !== 1'b0) begin $display("FAIL timeout busy high after %0d cycles", waited); errors++; end
    @(negedge clock); @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, done, error} !== 4'b0000) begin
      $display("FAIL reset_status got busy=%b done=%b error=%b exp all 0", busy, done, error); errors++;
    end
    checks++;
    if ({uart_read, uart_write, uart_data_cs, uart_status_cs, mem_write} !== 5'b00000) begin
      $display("FAIL reset_strobes got=%b exp=00000",
               {uart_read, uart_write, uart_data_cs, uart_status_cs, mem_write}); errors++;
    end
    checks++;
    if (mem_address !== BASE) begin $display("FAIL reset_addr got=%h exp=%h", mem_address, BASE); errors++; end
    checks++;
    if (uart_data_out !== 32'h0 || mem_data_out !== 32'h0) begin
      $display("FAIL reset_data got=%h/%h exp=0", uart_data_out, mem_data_out); errors++;
    end
  endtask

  task automatic test_two_words();
    logic d;
    valid_gap = 1'b1; ack_delay = 0; tx_hold = 0;
    load_stream(128'h00000002_11223344_AABBCCDD_00000000, 12, -1);
    run_load(3000, 30, d);
    valid_gap = 1'b0;
    checks++;
    if (d !== 1'b1 || error !== 2'b00) begin $display("FAIL two_done got done=%b err=%b exp 1/00", d, error); errors++; end
    checks++;
    if (done_cnt !== 1) begin $display("FAIL two_done_count got=%0d exp=1", done_cnt); errors++; end
    checks++;
    if (mem_cnt !== 2) begin $display("FAIL two_mem_count got=%0d exp=2", mem_cnt); errors++; end
    checks++;
    if (maddr_log[0] !== BASE || mdata_log[0] !== 32'h11223344) begin
      $display("FAIL two_word0 got=%h:%h exp=%h:11223344", maddr_log[0], mdata_log[0], BASE); errors++;
    end
    checks++;
    if (maddr_log[1] !== BASE + 30'd1 || mdata_log[1] !== 32'hAABBCCDD) begin
      $display("FAIL two_word1 got=%h:%h exp=%h:aabbccdd", maddr_log[1], mdata_log[1], BASE + 30'd1); errors++;
    end
    checks++;
    if (echo_cnt !== 12) begin $display("FAIL two_echo_count got=%0d exp=12", echo_cnt); errors++; end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (echo_log[i] !== rx_bytes[i]) begin
        $display("FAIL two_echo[%0d] got=%h exp=%h", i, echo_log[i], rx_bytes[i]); errors++;
      end
    end
    checks++;
    if (strobe_viol !== 0 || low_viol !== 0 || pend_viol !== 0) begin
      $display("FAIL two_protocol got strobe=%0d low=%0d pend=%0d exp 0", strobe_viol, low_viol, pend_viol); errors++;
    end
  endtask

  task automatic test_framing();
    logic d;
    load_stream(128'h00000002_11223344_00000000_00000000, 8, 2);
    run_load(2000, -1, d);
    checks++;
    if (d !== 1'b0 || error !== 2'b01 || busy !== 1'b0) begin
      $display("FAIL framing got done=%b err=%b busy=%b exp 0/01/0", d, error, busy); errors++;
    end
    checks++;
    if (echo_cnt !== 2 || mem_cnt !== 0) begin
      $display("FAIL framing_counts got echo=%0d mem=%0d exp 2/0", echo_cnt, mem_cnt); errors++;
    end
    repeat (5) @(negedge clock);
    checks++;
    if (error !== 2'b01) begin $display("FAIL framing_held got=%b exp=01", error); errors++; end
  endtask

  task automatic test_zero_header();
    logic d;
    load_stream(128'h00000000_00000000_00000000_00000000, 4, -1);
    run_load(2000, -1, d);
    checks++;
    if (d !== 1'b1 || error !== 2'b00) begin $display("FAIL zero_done got done=%b err=%b exp 1/00", d, error); errors++; end
    checks++;
    if (echo_cnt !== 4 || mem_cnt !== 0) begin
      $display("FAIL zero_counts got echo=%0d mem=%0d exp 4/0", echo_cnt, mem_cnt); errors++;
    end
  endtask

  task automatic test_oversize();
    logic d;
    load_stream(128'h00001001_00000000_00000000_00000000, 4, -1);
    run_load(2000, -1, d);
    checks++;
    if (d !== 1'b0 || error !== 2'b10) begin $display("FAIL oversize got done=%b err=%b exp 0/10", d, error); errors++; end
    checks++;
    if (echo_cnt !== 4 || mem_cnt !== 0) begin
      $display("FAIL oversize_counts got echo=%0d mem=%0d exp 4/0", echo_cnt, mem_cnt); errors++;
    end
  endtask

  task automatic test_mem_delay();
    logic d;
    ack_delay = 5;
    load_stream(128'h00000001_DEADBEEF_00000000_00000000, 8, -1);
    run_load(2000, -1, d);
    ack_delay = 0;
    checks++;
    if (d !== 1'b1 || mem_cnt !== 1) begin $display("FAIL delay_done got done=%b mem=%0d exp 1/1", d, mem_cnt); errors++; end
    checks++;
    if (maddr_log[0] !== BASE || mdata_log[0] !== 32'hDEADBEEF) begin
      $display("FAIL delay_word got=%h:%h exp=%h:deadbeef", maddr_log[0], mdata_log[0], BASE); errors++;
    end
    checks++;
    if (mem_run_max !== 6) begin $display("FAIL delay_run got=%0d exp=6", mem_run_max); errors++; end
    checks++;
    if (stab_viol !== 0 || store_strobe !== 0) begin
      $display("FAIL delay_stable got unstable=%0d strobes=%0d exp 0/0", stab_viol, store_strobe); errors++;
    end
  endtask

  task automatic test_tx_hold();
    logic d;
    tx_hold = 20;
    load_stream(128'h00000000_00000000_00000000_00000000, 4, -1);
    run_load(3000, -1, d);
    tx_hold = 0;
    checks++;
    if (d !== 1'b1 || echo_cnt !== 4) begin $display("FAIL txhold_done got done=%b echo=%0d exp 1/4", d, echo_cnt); errors++; end
    // bytes 1..3 each: one RX poll plus 16 TX polls while tx_ready is low
    checks++;
    if (blocked_polls !== 51) begin $display("FAIL txhold_polls got=%0d exp=51", blocked_polls); errors++; end
    checks++;
    if (pend_viol !== 0) begin $display("FAIL txhold_order got=%0d exp=0", pend_viol); errors++; end
  endtask

  task automatic test_reset_mid();
    logic d;
    load_stream(128'h00000001_01020304_00000000_00000000, 8, -1);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 300 && rx_ptr < 6; i++) @(negedge clock);
    checks++;
    if (rx_ptr < 6) begin $display("FAIL mid_reach got=%0d exp>=6", rx_ptr); errors++; end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, error, uart_read, uart_write, uart_data_cs, uart_status_cs, mem_write} !== 9'b0) begin
      $display("FAIL mid_reset_out got=%b exp=0",
               {busy, done, error, uart_read, uart_write, uart_data_cs, uart_status_cs, mem_write}); errors++;
    end
    checks++;
    if (mem_address !== BASE || uart_data_out !== 32'h0 || mem_data_out !== 32'h0) begin
      $display("FAIL mid_reset_data got=%h/%h/%h exp=%h/0/0", mem_address, uart_data_out, mem_data_out, BASE); errors++;
    end
    reset = 1'b0;
    checks++;
    if (mem_cnt !== 0) begin $display("FAIL mid_no_store got=%0d exp=0", mem_cnt); errors++; end
    load_stream(128'h00000001_CAFEBABE_00000000_00000000, 8, -1);
    run_load(2000, -1, d);
    checks++;
    if (d !== 1'b1 || mem_cnt !== 1 || maddr_log[0] !== BASE || mdata_log[0] !== 32'hCAFEBABE) begin
      $display("FAIL mid_reload got done=%b mem=%0d %h:%h exp 1/1 %h:cafebabe",
               d, mem_cnt, maddr_log[0], mdata_log[0], BASE); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_framing();
    test_zero_header();
    test_oversize();
    test_mem_delay();
    test_tx_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Bus initiator that drives the register side of the UART interface block: data register and status register, via read/write/data_cs/status_cs.
- On start, polls status and receives a big-endian word-count header. It then receives that many 32-bit big-endian words and writes each into memory at consecutive word addresses.
- Every received byte is echoed back over the UART transmitter for host flow control.
- Sits beside the CPU as a boot-time master. It is muxed onto the UART and memory buses only while busy.

Parameters:
- BASE_ADDR, 30'h0000000, word address of first stored word.
- MAX_WORDS, 4096, largest accepted word count; a larger header aborts.
- TX_GUARD_CYCLES, 2, idle cycles after a TX data write before tx_ready is polled again.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a load; ignored unless idle
- busy  out  1  high from accepted start until done/error
- done  out  1  one-cycle pulse on successful completion
- error  out  2  00 none, 01 framing error, 10 oversize header; held until next start
- uart_read  out  1  UART bus read strobe
- uart_write  out  1  UART bus write strobe
- uart_data_cs  out  1  selects data register
- uart_status_cs  out  1  selects status register
- uart_data_out  out  32  TX byte in [31:24], zeros below
- uart_data_in  in  32  status: bit31 rx_ready, bit30 framing_error, bit29 tx_ready; data: byte in [31:24]
- uart_data_in_valid  in  1  read data valid, combinational in same cycle as strobe
- mem_write  out  1  held high until mem_ack
- mem_address  out  30  word address
- mem_data_out  out  32  word to store
- mem_ack  in  1  memory accepted write this cycle

Behaviour:
- Reset: all strobes/cs 0, busy 0, done 0, error 00, mem_write 0, mem_address BASE_ADDR, data outputs 0, state IDLE. Reset mid-operation aborts immediately. No partial write completes after reset.
- Each bus access lasts exactly one cycle. Read data is sampled in the strobe cycle when uart_data_in_valid=1. If valid=0, the access repeats next cycle.
- IDLE -> POLL_RX on start; error cleared, byte counter 0, word index 0.
- POLL_RX: status read.
  - rx_ready=1 -> READ_DATA.
  - Otherwise stay (one poll per cycle).
- READ_DATA: data read. The byte is shifted into the assembly register MSB-first, which also clears the flags in the UART.
  - If framing_error was set in the preceding status sample -> ERROR with code 01. The byte is discarded and not echoed.
  - Else -> POLL_TX.
- POLL_TX: status read.
  - tx_ready=1 -> WRITE_TX.
  - Otherwise stay.
- WRITE_TX: data write with byte in [31:24] -> TX_GUARD.
- TX_GUARD: counts TX_GUARD_CYCLES idle cycles, then branches on the 2-bit byte counter:
  - 4th byte of header -> CHECK.
  - 4th byte of payload word -> STORE.
  - Otherwise -> POLL_RX.
- CHECK:
  - count=0 -> DONE.
  - count>MAX_WORDS -> ERROR with code 10.
  - Otherwise latch the remaining count -> POLL_RX.
- STORE: mem_write=1, mem_address=BASE_ADDR+index, mem_data_out=assembled word. All three are held stable until mem_ack. No UART access occurs during STORE.
  - On mem_ack: index+1, remaining-1. remaining reaches 0 -> DONE, else POLL_RX.
- DONE: done pulses 1 cycle, busy falls in the same cycle -> IDLE.
- ERROR: busy falls, error is latched -> IDLE.
- At most one of uart_read/uart_write is high in any cycle.
- busy is high in every non-IDLE state except the final DONE/ERROR cycle.
- start while busy is ignored.
- Header comparison is 32-bit unsigned.
- mem_address arithmetic is 30-bit and wraps silently.
- TX_GUARD exists because tx_ready deasserts some cycles after the write.

Decomposition:
- Shared package uart_pkg:
  - Status bit indices: RX_READY=31, FRAMING_ERROR=30, TX_READY=29.
  - Byte lane constants [31:24].
  - Error code localparams.
  - State enumeration.
- One natural sub-module, uart_bus_port. It performs a single one-cycle read/write access to status or data and returns a captured word plus an ack. This lets the FSM reuse it for the RX and TX polls.

Test Plan:
- Header 00000002, payload 11223344 AABBCCDD -> the following, then one done pulse with error=00:
  - mem writes (BASE,11223344) and (BASE+1,AABBCCDD).
  - 12 echoed bytes matching the input order.
- Header 00000000 -> done 4 bytes later, no mem_write, 4 echo bytes.
- Framing error on 3rd header byte -> error=01, busy low, no mem_write, exactly 2 echo bytes.
- Header 00001001 with MAX_WORDS=4096 -> error=10 after 4th echo, no mem_write.
- mem_ack delayed 5 cycles -> mem_write, address and data stable for 6 cycles, zero UART strobes meanwhile.
- tx_ready held low 20 cycles after a byte -> continuous tx polls, no data read until the echo is written.
- Reset asserted mid-word, then start -> all outputs at reset values next cycle; the new load stores at BASE_ADDR correctly.
